// File: rtl/alu_pkg.sv
// Shared opcode and FSM definitions for the two-requester bitwise logic unit.
// Also holds the round-robin pick rule so the arbiter and any future reuse agree on it.
package alu_pkg;

    localparam logic [1:0] ALU_AND  = 2'b00;
    localparam logic [1:0] ALU_OR   = 2'b01;
    localparam logic [1:0] ALU_XOR  = 2'b10;
    localparam logic [1:0] ALU_XNOR = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        EXEC = 2'b01,
        RESP = 2'b10
    } state_e;

    // Both requesting: the pointer decides; otherwise whoever is asking wins.
    function automatic logic rr_pick(input logic v0, input logic v1, input logic ptr);
        return (v0 && v1) ? ptr : v1;
    endfunction

endpackage

// File: rtl/alu_logic_unit.sv
// Purely combinational WIDTH-bit bitwise logic unit (AND/OR/XOR/XNOR).
module alu_logic_unit
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] y
);

    // Bitwise operation select
    always_comb begin
        y = {WIDTH{1'b0}};
        case (op)
            ALU_AND:  y = a & b;
            ALU_OR:   y = a | b;
            ALU_XOR:  y = a ^ b;
            ALU_XNOR: y = ~(a ^ b);
            default:  y = {WIDTH{1'b0}};
        endcase
    end

endmodule

// File: rtl/alu_logic_arbiter.sv
// Round-robin front end sharing one bitwise logic unit between two requesters,
// with valid/ready on both sides and a registered result held until consumed.
module alu_logic_arbiter
    import alu_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter bit ZERO_EN = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [1:0]       req0_op,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [1:0]       req1_op,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_y,
    output logic             rsp_zero,
    output logic             busy
);

    state_e           state_q, state_d;
    logic             ptr_q, ptr_d;
    logic [1:0]       op_q, op_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             id_q, id_d;
    logic [WIDTH-1:0] y_q, y_d;
    logic             zero_q, zero_d;
    logic             rsp_id_q, rsp_id_d;

    logic             gnt_any_s;
    logic             gnt_id_s;
    logic             grant_s;
    logic [WIDTH-1:0] alu_y_s;

    assign gnt_any_s = req0_valid | req1_valid;
    assign gnt_id_s  = rr_pick(req0_valid, req1_valid, ptr_q);
    // Ready is gated by rst_n so every output reads 0 while reset is held.
    assign grant_s   = rst_n & (state_q == IDLE) & gnt_any_s;

    assign req0_ready = grant_s & ~gnt_id_s;
    assign req1_ready = grant_s &  gnt_id_s;
    assign rsp_valid  = (state_q == RESP);
    assign busy       = (state_q != IDLE);
    assign rsp_id     = rsp_id_q;
    assign rsp_y      = y_q;
    assign rsp_zero   = zero_q;

    alu_logic_unit #(
        .WIDTH (WIDTH)
    ) u_unit (
        .op (op_q),
        .a  (a_q),
        .b  (b_q),
        .y  (alu_y_s)
    );

    // Next-state, operand latch and result capture
    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        op_d     = op_q;
        a_d      = a_q;
        b_d      = b_q;
        id_d     = id_q;
        y_d      = y_q;
        zero_d   = zero_q;
        rsp_id_d = rsp_id_q;
        case (state_q)
            IDLE: begin
                if (grant_s) begin
                    state_d = EXEC;
                    ptr_d   = ~gnt_id_s;
                    id_d    = gnt_id_s;
                    op_d    = gnt_id_s ? req1_op : req0_op;
                    a_d     = gnt_id_s ? req1_a  : req0_a;
                    b_d     = gnt_id_s ? req1_b  : req0_b;
                end else begin
                    state_d = IDLE;
                end
            end
            EXEC: begin
                state_d  = RESP;
                y_d      = alu_y_s;
                zero_d   = ZERO_EN ? (alu_y_s == {WIDTH{1'b0}}) : 1'b0;
                rsp_id_d = id_q;
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end else begin
                    state_d = RESP;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, pointer, operand and result registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            ptr_q    <= 1'b0;
            op_q     <= 2'b00;
            a_q      <= {WIDTH{1'b0}};
            b_q      <= {WIDTH{1'b0}};
            id_q     <= 1'b0;
            y_q      <= {WIDTH{1'b0}};
            zero_q   <= 1'b0;
            rsp_id_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            op_q     <= op_d;
            a_q      <= a_d;
            b_q      <= b_d;
            id_q     <= id_d;
            y_q      <= y_d;
            zero_q   <= zero_d;
            rsp_id_q <= rsp_id_d;
        end
    end

endmodule

// File: tb/tb_alu_logic_arbiter.sv
// Scoreboard bench: a transaction-level tracker predicts grants and results,
// a separate monitor compares every presented response against the queue.
module tb_alu_logic_arbiter;
    import alu_pkg::*;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         req0_valid, req1_valid;
    logic         req0_ready, req1_ready;
    logic [1:0]   req0_op, req1_op;
    logic [W-1:0] req0_a, req0_b, req1_a, req1_b;
    logic         rsp_valid, rsp_ready, rsp_id, rsp_zero, busy;
    logic [W-1:0] rsp_y;

    typedef struct {
        logic         id;
        logic [W-1:0] y;
        logic         zero;
        int           acc;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    int   drv_timeouts = 0;
    int   drain_req = 0;
    bit   pend[2];
    bit   acc[2];

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    alu_logic_arbiter #(.WIDTH(W), .ZERO_EN(1'b1)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
        .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
        .req1_a(req1_a), .req1_b(req1_b),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_y(rsp_y), .rsp_zero(rsp_zero), .busy(busy)
    );

    function automatic logic [W-1:0] ref_op(input logic [1:0] op, input logic [W-1:0] a,
                                            input logic [W-1:0] b);
        case (op)
            2'b00:   return a & b;
            2'b01:   return a | b;
            2'b10:   return a ^ b;
            default: return ~(a ^ b);
        endcase
    endfunction

    // Tracker: applies the arbitration rules to the requests on the bus and queues expectations
    initial begin : tracker
        bit   m_idle;
        bit   m_ptr;
        logic g;
        exp_t e;
        m_idle = 1'b1;
        m_ptr  = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                m_idle = 1'b1;
                m_ptr  = 1'b0;
            end else if (m_idle) begin
                if (req0_valid || req1_valid) begin
                    g      = (req0_valid && req1_valid) ? m_ptr : req1_valid;
                    e.id   = g;
                    e.y    = g ? ref_op(req1_op, req1_a, req1_b) : ref_op(req0_op, req0_a, req0_b);
                    e.zero = (e.y == 32'd0);
                    e.acc  = cyc;
                    sb.push_back(e);
                    m_idle = 1'b0;
                    m_ptr  = ~g;
                end
            end else if (rsp_valid && rsp_ready) begin
                m_idle = 1'b1;
            end
        end
    end

    // Monitor: the only process that compares and counts
    initial begin : monitor
        exp_t e;
        bit   first_seen;
        int   to_seen;
        int   drain_seen;
        first_seen = 1'b0;
        to_seen    = 0;
        drain_seen = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                checks++;
                if (rsp_valid !== 1'b0 || busy !== 1'b0 || req0_ready !== 1'b0 ||
                    req1_ready !== 1'b0 || rsp_id !== 1'b0 || rsp_zero !== 1'b0 ||
                    rsp_y !== 32'd0) begin
                    errors++;
                    $display("FAIL reset_outputs: got valid=%b busy=%b rdy=%b%b id=%b zero=%b y=%h, want all 0",
                             rsp_valid, busy, req0_ready, req1_ready, rsp_id, rsp_zero, rsp_y);
                end
                sb.delete();
                first_seen = 1'b0;
            end else begin
                if (to_seen != drv_timeouts) begin
                    checks++;
                    errors++;
                    $display("FAIL drain_timeout: got %0d timeouts, want 0", drv_timeouts);
                    to_seen = drv_timeouts;
                end
                if (drain_seen != drain_req) begin
                    checks++;
                    if (sb.size() != 0) begin
                        errors++;
                        $display("FAIL scoreboard_empty: got %0d pending, want 0", sb.size());
                    end
                    drain_seen = drain_req;
                end
                if (rsp_valid) begin
                    checks++;
                    if (busy !== 1'b1 || req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
                        errors++;
                        $display("FAIL resp_state: got busy=%b rdy=%b%b, want busy=1 rdy=00",
                                 busy, req0_ready, req1_ready);
                    end
                    checks++;
                    if (sb.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_rsp: got rsp_valid=1 id=%b y=%h, want no response",
                                 rsp_id, rsp_y);
                    end else begin
                        e = sb[0];
                        if (!first_seen) begin
                            checks++;
                            if (cyc - e.acc != 2) begin
                                errors++;
                                $display("FAIL latency: got %0d cycles, want 2", cyc - e.acc);
                            end
                            first_seen = 1'b1;
                        end
                        checks++;
                        if (rsp_id !== e.id || rsp_y !== e.y || rsp_zero !== e.zero) begin
                            errors++;
                            $display("FAIL rsp_data: got id=%b y=%h zero=%b, want id=%b y=%h zero=%b",
                                     rsp_id, rsp_y, rsp_zero, e.id, e.y, e.zero);
                        end
                        if (rsp_ready) begin
                            void'(sb.pop_front());
                            first_seen = 1'b0;
                        end
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got no finish by 200000, want finish");
        $fatal(1);
    end

    task automatic set_req(input int k, input bit v, input logic [1:0] op,
                           input logic [W-1:0] a, input logic [W-1:0] b);
        if (k == 0) begin
            req0_valid = v; req0_op = op; req0_a = a; req0_b = b;
        end else begin
            req1_valid = v; req1_op = op; req1_a = a; req1_b = b;
        end
    endtask

    // After each edge: retire accepted requests and scramble their now-free operands
    task automatic half_start();
        @(posedge clk);
        #1;
        for (int k = 0; k < 2; k++) begin
            if (acc[k]) begin
                pend[k] = 1'b0;
                set_req(k, 1'b0, 2'($urandom_range(3)), $urandom, $urandom);
            end
        end
    endtask

    task automatic half_end();
        @(negedge clk);
        acc[0] = req0_ready;
        acc[1] = req1_ready;
    endtask

    task automatic tick(input int p_new, input int p_rdy, input int p_drop);
        half_start();
        for (int k = 0; k < 2; k++) begin
            if (pend[k] && $urandom_range(99) < p_drop) begin
                pend[k] = 1'b0;
                set_req(k, 1'b0, 2'($urandom_range(3)), $urandom, $urandom);
            end else if (!pend[k] && $urandom_range(99) < p_new) begin
                pend[k] = 1'b1;
                set_req(k, 1'b1, 2'($urandom_range(3)), $urandom, $urandom);
            end
        end
        rsp_ready = ($urandom_range(99) < p_rdy);
        half_end();
    endtask

    task automatic issue(input int k, input logic [1:0] op, input logic [W-1:0] a,
                         input logic [W-1:0] b);
        half_start();
        pend[k] = 1'b1;
        set_req(k, 1'b1, op, a, b);
        rsp_ready = 1'b1;
        half_end();
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((pend[0] || pend[1] || sb.size() != 0 || rsp_valid) && n < 60) begin
            tick(0, 100, 0);
            n++;
        end
        if (n >= 60) drv_timeouts++;
    endtask

    task automatic do_reset();
        half_start();
        rst_n = 1'b0;
        pend[0] = 1'b0;
        pend[1] = 1'b0;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        half_end();
        half_start();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        half_end();
        half_start();
        rst_n = 1'b1;
        half_end();
    endtask

    initial begin : driver
        rst_n = 1'b0;
        rsp_ready = 1'b0;
        pend[0] = 1'b0; pend[1] = 1'b0;
        acc[0] = 1'b0;  acc[1] = 1'b0;
        set_req(0, 1'b0, 2'b00, 32'd0, 32'd0);
        set_req(1, 1'b0, 2'b00, 32'd0, 32'd0);
        do_reset();

        issue(0, ALU_XOR, 32'hFFFF0000, 32'h0F0F0F0F);
        drain();
        issue(1, ALU_AND, 32'hAAAAAAAA, 32'h55555555);
        drain();

        // Both requesters held valid: grants must alternate starting from requester 0
        do_reset();
        half_start();
        pend[0] = 1'b1;
        pend[1] = 1'b1;
        set_req(0, 1'b1, 2'($urandom_range(3)), $urandom, $urandom);
        set_req(1, 1'b1, 2'($urandom_range(3)), $urandom, $urandom);
        rsp_ready = 1'b1;
        half_end();
        repeat (11) tick(100, 100, 0);
        drain();

        // Consumer stalls in RESP while the other requester waits
        issue(0, ALU_OR, $urandom, $urandom);
        issue(1, ALU_XNOR, $urandom, $urandom);
        repeat (6) tick(0, 0, 0);
        drain();

        // Reset during EXEC discards the in-flight operation
        issue(0, ALU_XNOR, $urandom, $urandom);
        half_start();
        rst_n = 1'b0;
        pend[0] = 1'b0;
        pend[1] = 1'b0;
        req1_valid = 1'b1;
        half_end();
        half_start();
        req1_valid = 1'b0;
        half_end();
        half_start();
        rst_n = 1'b1;
        half_end();
        repeat (8) tick(0, 100, 0);

        repeat (600) tick(30, 70, 5);
        drain();

        half_start();
        drain_req = 1;
        half_end();
        half_start();
        half_end();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
